gpio_pattern_gen: RTL and testbench

//   Downstream consumer of the GPIO divided-clock strobe (div_clk, a square wave generated in the clk domain).

---
 rtl/gpio_pattern_gen.sv | 105 ++++++++++
 tb/tb_gpio_pattern_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_pattern_gen.sv
// Pattern-word FIFO that drives GPIO pins, popping one word per rising edge of div_clk.
// div_clk is sampled in the clk domain, so the pins advance at the divided rate with no second clock.
//
// state | meaning
// IDLE  | pins tri-stated (gpio_oe=0); ticks ignored; FIFO still accepts pushes
// RUN   | pins driven; each div_clk rise pops one word or flags underrun

module gpio_pattern_gen #(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       div_clk,
    input  logic                       en,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           gpio_out,
    output logic                       gpio_oe,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       underrun,
    input  logic                       clr_underrun
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            div_q;
    logic            tick;
    logic            push;
    logic            pop;
    logic            underrun_set;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign next_state   = en ? RUN : IDLE;
    assign tick         = div_clk & ~div_q;
    assign in_ready     = (level != FULL_LEVEL);
    assign push         = in_valid & in_ready;
    assign pop          = (state == RUN) & tick & (level != '0);
    assign underrun_set = (state == RUN) & tick & (level == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gpio_oe  <= 1'b0;
            gpio_out <= IDLE_VAL;
            div_q    <= 1'b0;
            underrun <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
        end else begin
            div_q   <= div_clk;
            state   <= next_state;
            gpio_oe <= (next_state == RUN);

            // Set takes priority so a tick that finds the FIFO empty is never lost.
            if (underrun_set) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                level  <= '0;
            end else begin
                if (pop) begin
                    gpio_out <= mem[rd_ptr];
                    rd_ptr   <= rd_ptr + PW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (push && !pop) begin
                    level <= level + LW'(1);
                end else if (pop && !push) begin
                    level <= level - LW'(1);
                end
            end
        end
    end

    // Storage is left unreset; only the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_gpio_pattern_gen.sv
// Bench for gpio_pattern_gen: directed scenarios plus random traffic, all checked
// against a queue-based model of the pattern FIFO and pin behaviour.

module tb_gpio_pattern_gen;

    localparam logic [7:0] IDLE_V = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n, div_clk, en, flush, in_valid, clr_underrun;
    logic [7:0] in_data;
    logic       in_ready, gpio_oe, underrun;
    logic [7:0] gpio_out;
    logic [2:0] level;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_q[$];
    bit         m_run;
    logic [7:0] m_out;
    bit         m_und;
    bit         m_divp;

    gpio_pattern_gen #(.WIDTH(8), .DEPTH(4), .IDLE_VAL(IDLE_V)) dut (
        .clk(clk), .rst_n(rst_n), .div_clk(div_clk), .en(en), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe), .level(level),
        .underrun(underrun), .clr_underrun(clr_underrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // One clock: update the model from the inputs seen at the edge, then compare.
    task automatic step();
        bit tick, push, pop, und_set;
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_run  = 1'b0;
            m_out  = IDLE_V;
            m_und  = 1'b0;
            m_divp = 1'b0;
        end else begin
            tick    = div_clk && !m_divp;
            m_divp  = div_clk;
            push    = in_valid && (m_q.size() != 4);
            pop     = m_run && tick && (m_q.size() != 0);
            und_set = m_run && tick && (m_q.size() == 0);
            if (flush) begin
                m_q.delete();
            end else begin
                if (pop) m_out = m_q.pop_front();
                if (push) m_q.push_back(in_data);
            end
            if (und_set) m_und = 1'b1;
            else if (clr_underrun) m_und = 1'b0;
            m_run = en;
        end
        #1;
        check_eq("gpio_out", gpio_out, m_out);
        check_eq("gpio_oe", gpio_oe, m_run);
        check_eq("level", level, m_q.size());
        check_eq("underrun", underrun, m_und);
        check_eq("in_ready", in_ready, m_q.size() != 4);
    endtask

    task automatic idle_inputs();
        in_valid = 0; flush = 0; clr_underrun = 0;
    endtask

    task automatic push_word(input logic [7:0] d);
        in_valid = 1; in_data = d;
        step();
        in_valid = 0;
    endtask

    // div_clk high for one cycle (tick), then low for two.
    task automatic rise();
        div_clk = 1; step();
        div_clk = 0; step(); step();
    endtask

    initial begin
        logic [7:0] exp2 [4];
        logic [7:0] exp5 [4];
        exp2[0] = 8'h01; exp2[1] = 8'h02; exp2[2] = 8'h04; exp2[3] = 8'h08;
        exp5[0] = 8'h11; exp5[1] = 8'h12; exp5[2] = 8'h13; exp5[3] = 8'h77;

        rst_n = 0; div_clk = 0; en = 0; in_data = 0;
        m_out = IDLE_V;
        idle_inputs();
        step(); step();

        // Reset value holds while div_clk toggles in IDLE.
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            div_clk = ~div_clk; step();
        end
        div_clk = 0; step();
        check_eq("rst_gpio_out", gpio_out, IDLE_V);
        check_eq("rst_gpio_oe", gpio_oe, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_underrun", underrun, 0);

        // Four words stepped out one per div_clk rise.
        push_word(8'h01); push_word(8'h02); push_word(8'h04); push_word(8'h08);
        check_eq("s2_level_full", level, 4);
        en = 1; step();
        for (int i = 0; i < 4; i++) begin
            div_clk = 1; step();
            check_eq("s2_word", gpio_out, exp2[i]);
            check_eq("s2_level", level, 3 - i);
            div_clk = 0; step(); step();
        end
        check_eq("s2_no_underrun", underrun, 0);

        // Empty tick in RUN sets underrun; clear on a second empty tick loses.
        div_clk = 1; step();
        check_eq("s4_underrun", underrun, 1);
        check_eq("s4_hold", gpio_out, 8'h08);
        div_clk = 0; step();
        div_clk = 1; clr_underrun = 1; step();
        check_eq("s4_set_wins", underrun, 1);
        div_clk = 0; step();
        check_eq("s4_cleared", underrun, 0);
        clr_underrun = 0;

        // Overfill while IDLE.
        en = 0; step();
        for (int i = 0; i < 6; i++) push_word(8'h10 + 8'(i));
        check_eq("s3_level", level, 4);
        check_eq("s3_ready", in_ready, 0);

        // Pop and refused push on a full FIFO, then push across the wrap.
        en = 1; step();
        div_clk = 1; in_valid = 1; in_data = 8'h77; step();
        check_eq("s5_level3", level, 3);
        check_eq("s5_pop", gpio_out, 8'h10);
        step();
        in_valid = 0;
        check_eq("s5_level4", level, 4);
        div_clk = 0; step();
        for (int i = 0; i < 4; i++) begin
            div_clk = 1; step();
            check_eq("s5_order", gpio_out, exp5[i]);
            div_clk = 0; step();
        end

        // Flush beats a same-cycle push; reset mid-RUN.
        en = 0; step();
        push_word(8'h21); push_word(8'h22); push_word(8'h23);
        flush = 1; in_valid = 1; in_data = 8'h24; step();
        flush = 0; in_valid = 0;
        check_eq("s6_flush", level, 0);
        en = 1;
        push_word(8'h31); push_word(8'h32);
        rise();
        rst_n = 0; step();
        check_eq("s6_rst_gpio", gpio_out, IDLE_V);
        check_eq("s6_rst_oe", gpio_oe, 0);
        check_eq("s6_rst_level", level, 0);
        check_eq("s6_rst_und", underrun, 0);
        rst_n = 1; en = 0; div_clk = 0; step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(0, 199) != 0);
            en           = ($urandom_range(0, 9) != 0);
            div_clk      = ($urandom_range(0, 2) == 0) ? ~div_clk : div_clk;
            in_valid     = $urandom_range(0, 1);
            in_data      = 8'($urandom);
            flush        = ($urandom_range(0, 39) == 0);
            clr_underrun = ($urandom_range(0, 14) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
